fwft_word_packer: RTL

- Sits directly downstream of the dual-clock first-word-fall-through (FWFT) FIFO, in its read-clock domain.
- Drains narrow FWFT words from the FIFO and packs RATIO consecutive words into one wide output word.
- Presents the wide word on a registered valid/ready interface, for example to a DMA or bus-width adapter.
- A flush input forces out a partially filled word, marked by a per-lane keep mask.

---
 rtl/fwft_pack_pkg.sv | 38 +++
 rtl/fwft_word_packer_out_reg.sv | 54 +++++
 rtl/fwft_word_packer.sv | 116 +++++++++++
 3 files changed

// File: rtl/fwft_pack_pkg.sv
// Shared types and lane helpers for the FWFT word packer.
package fwft_pack_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    localparam int MAX_RATIO = 32;

    function automatic logic [4:0] lane_index(
        input logic [5:0] cnt,
        input logic       swap,
        input int         ratio
    );
        int l;
        l = swap ? (ratio - 1 - int'(cnt)) : int'(cnt);
        return 5'(l);
    endfunction

    // Lanes already written after cnt pops, seen from the placement order.
    function automatic logic [MAX_RATIO-1:0] keep_mask(
        input logic [5:0] cnt,
        input logic       swap,
        input int         ratio
    );
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            if (swap)
                m[i] = (i < ratio) && (i >= ratio - int'(cnt));
            else
                m[i] = (i < int'(cnt));
        end
        return m;
    endfunction

endpackage

// File: rtl/fwft_word_packer_out_reg.sv
// Single-entry valid/ready output register with load and stall.
module pack_out_reg
    import fwft_pack_pkg::*;
#(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic [KW-1:0] out_keep,
    output logic          out_vld,
    output logic          slot_free
);

    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        vld_d  = vld_q;
        if (load) begin
            data_d = load_data;
            keep_d = load_keep;
            vld_d  = 1'b1;
        end else if (out_rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            keep_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
            vld_q  <= vld_d;
        end
    end

    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_vld   = vld_q;
    assign slot_free = ~vld_q | out_rdy;

endmodule

// File: rtl/fwft_word_packer.sv
// Packs RATIO narrow FWFT FIFO words into one wide valid/ready word,
// with flush support for partially filled words.
module fwft_word_packer
    import fwft_pack_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int WORD_SWAP = 0
) (
    input  logic                      clk,
    input  logic                      clk_rst,
    output logic                      fifo_rden,
    input  logic [IN_WIDTH-1:0]       fifo_rdata,
    input  logic                      fifo_rdata_vld,
    input  logic                      flush,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic                      busy
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CW = $clog2(RATIO) + 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
    localparam logic SWAP = (WORD_SWAP != 0);

    pack_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_post;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, acc_pop;
    logic [OUT_WIDTH-1:0] load_data;
    logic [RATIO-1:0]     load_keep;
    logic [4:0]           lane;
    logic                 slot_free, pop, last_pop, load;

    assign fifo_rden = fifo_rdata_vld & (state_q == FILL)
                     & ((cnt_q < LAST) | slot_free);
    assign pop       = fifo_rden;
    assign last_pop  = pop & (cnt_q == LAST);
    assign lane      = lane_index(6'(cnt_q), SWAP, RATIO);
    assign cnt_post  = pop ? cnt_q + CW'(1) : cnt_q;

    always_comb begin
        acc_pop = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            if (pop && lane == 5'(i))
                acc_pop[i*IN_WIDTH +: IN_WIDTH] = fifo_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        load      = 1'b0;
        load_data = acc_pop;
        load_keep = '1;
        unique case (state_q)
            FILL: begin
                if (last_pop) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    acc_d = '0;
                end else begin
                    cnt_d = cnt_post;
                    acc_d = acc_pop;
                    // A flush that would leave nothing to emit is dropped.
                    if (flush && cnt_post != '0)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = acc_q;
                    load_keep = RATIO'(keep_mask(6'(cnt_q), SWAP, RATIO));
                    cnt_d     = '0;
                    acc_d     = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    pack_out_reg #(
        .DW(OUT_WIDTH),
        .KW(RATIO)
    ) u_out (
        .clk       (clk),
        .rst       (clk_rst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_vld   (out_vld),
        .slot_free (slot_free)
    );

    assign busy = (cnt_q != '0) | (state_q == FLUSH) | out_vld;

endmodule
